// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, constants and address helper for the Sobel pixel fetcher
package sobel_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fetch_state_t;

   localparam int IMG_WIDTH     = 640;
   localparam int BYTES_PER_PIX = 4;
   localparam int ROW_STRIDE    = IMG_WIDTH * BYTES_PER_PIX;
   localparam int PIX_W         = 8;

   typedef logic [8:0][PIX_W-1:0] win_t;

   // Byte offset of request k in a column-major walk: row k%3, column k/3.
   function automatic logic [31:0] req_offset(input logic [3:0] k, input logic [31:0] stride);
      logic [3:0] row;
      logic [3:0] col;
      row = k % 4'd3;
      col = k / 4'd3;
      return ({28'd0, row} * stride) + ({28'd0, col} << 2);
   endfunction

endpackage

// File: rtl/sobel_window_shift3x3.sv
// rtl/sobel_window_shift3x3.sv - column buffer, shifting working window and output copy
module sobel_window_shift3x3 #(
   parameter int PIX_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_valid,
   input  logic [1:0]         pix_row,
   input  logic [PIX_W-1:0]   pix,
   input  logic               copy_en,
   output logic [9*PIX_W-1:0] window
);

   logic [2:0][PIX_W-1:0] col_buf_q, col_buf_d;
   logic [8:0][PIX_W-1:0] work_q, work_d;
   logic [8:0][PIX_W-1:0] win_q, win_d;

   // Buffer pixels by row; the third pixel of a column shifts the working window left.
   always_comb begin
      col_buf_d = col_buf_q;
      work_d    = work_q;
      win_d     = win_q;
      if (pix_valid) begin
         col_buf_d[pix_row] = pix;
         if (pix_row == 2'd2) begin
            for (int r = 0; r < 3; r++) begin
               work_d[r*3+0] = work_q[r*3+1];
               work_d[r*3+1] = work_q[r*3+2];
               work_d[r*3+2] = col_buf_d[r];
            end
         end
      end
      // Copy the post-shift window so a shift and a copy in the same cycle agree.
      if (copy_en) begin
         win_d = work_d;
      end
   end

   // Register buffer, working window and visible window.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_buf_q <= '0;
         work_q    <= '0;
         win_q     <= '0;
      end else begin
         col_buf_q <= col_buf_d;
         work_q    <= work_d;
         win_q     <= win_d;
      end
   end

   assign window = win_q;

endmodule

// File: rtl/sobel_pixel_fetcher.sv
// rtl/sobel_pixel_fetcher.sv - Avalon-MM read master assembling a 3x3 pixel window
module sobel_pixel_fetcher
   import sobel_pkg::*;
#(
   parameter int PIX_W       = sobel_pkg::PIX_W,
   parameter int ROW_STRIDE  = sobel_pkg::ROW_STRIDE,
   parameter int MAX_PENDING = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               loadStart,
   input  logic [31:0]        readAddress,
   input  logic [3:0]         numPixToLoad,
   output logic               busy,
   output logic               loadDone,
   output logic [9*PIX_W-1:0] window,
   output logic [31:0]        avm_address,
   output logic               avm_read,
   input  logic               avm_waitrequest,
   input  logic [31:0]        avm_readdata,
   input  logic               avm_readdatavalid
);

   fetch_state_t state_q, state_d;
   logic [31:0]  base_q, base_d;
   logic [3:0]   num_q, num_d;
   logic [3:0]   issue_q, issue_d;
   logic [3:0]   recv_q, recv_d;
   logic [3:0]   pending_q, pending_d;
   logic         avm_read_q, avm_read_d;
   logic [31:0]  avm_address_q, avm_address_d;
   logic         busy_q, busy_d;
   logic         load_done_q, load_done_d;

   logic         accept;
   logic         resp;
   logic [1:0]   recv_row;
   logic         unused_rdata;

   assign accept       = avm_read_q && !avm_waitrequest;
   // Responses outside an active load are stale and dropped.
   assign resp         = avm_readdatavalid && (state_q == ISSUE || state_q == DRAIN);
   assign recv_row     = 2'(recv_q % 4'd3);
   assign unused_rdata = ^avm_readdata[31:PIX_W];

   // Next-state, counter and bus-output computation.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      num_d     = num_q;
      issue_d   = issue_q + {3'd0, accept};
      recv_d    = recv_q + {3'd0, resp};
      pending_d = pending_q + {3'd0, accept} - {3'd0, resp};
      case (state_q)
         IDLE: begin
            if (loadStart) begin
               state_d   = ISSUE;
               base_d    = readAddress;
               num_d     = (numPixToLoad == 4'd3) ? 4'd3 : 4'd9;
               issue_d   = 4'd0;
               recv_d    = 4'd0;
               pending_d = 4'd0;
            end
         end
         ISSUE: begin
            if (accept && issue_d == num_q) begin
               state_d = (recv_d == num_q) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (recv_q == num_q) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      avm_read_d    = (state_d == ISSUE) && (pending_d < 4'(MAX_PENDING));
      avm_address_d = base_d + req_offset(issue_d, 32'(ROW_STRIDE));
      busy_d        = (state_d != IDLE);
      load_done_d   = (state_d == DONE);
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         base_q        <= '0;
         num_q         <= '0;
         issue_q       <= '0;
         recv_q        <= '0;
         pending_q     <= '0;
         avm_read_q    <= 1'b0;
         avm_address_q <= '0;
         busy_q        <= 1'b0;
         load_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         num_q         <= num_d;
         issue_q       <= issue_d;
         recv_q        <= recv_d;
         pending_q     <= pending_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         busy_q        <= busy_d;
         load_done_q   <= load_done_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign loadDone    = load_done_q;

   sobel_window_shift3x3 #(
      .PIX_W (PIX_W)
   ) u_window (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (resp),
      .pix_row   (recv_row),
      .pix       (avm_readdata[PIX_W-1:0]),
      .copy_en   (state_d == DONE),
      .window    (window)
   );

endmodule

// File: tb/tb_sobel_pixel_fetcher.sv
// tb/tb_sobel_pixel_fetcher.sv - directed self-checking bench for sobel_pixel_fetcher
module tb_sobel_pixel_fetcher;

   logic        clk = 1'b0;
   logic        rst;
   logic        loadStart;
   logic [31:0] readAddress;
   logic [3:0]  numPixToLoad;
   logic        busy;
   logic        loadDone;
   logic [71:0] window;
   logic [31:0] avm_address;
   logic        avm_read;
   logic        avm_waitrequest   = 1'b0;
   logic [31:0] avm_readdata      = '0;
   logic        avm_readdatavalid = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   int lat_cfg    = 1;
   int stall_idx  = -1;
   int stall_left = 0;
   int stall_seen = 0;
   int hold_bad   = 0;
   int max_q      = 0;
   int done_cnt   = 0;
   logic [31:0] stall_addr = '0;
   logic [31:0] acc_log[$];
   logic [31:0] q_addr[$];
   int          q_due[$];

   int OFF[9] = '{0, 2560, 5120, 4, 2564, 5124, 8, 2568, 5128};
   int W9[9]  = '{0, 1, 2, 128, 129, 130, 0, 1, 2};
   int W3[9]  = '{1, 2, 3, 129, 130, 131, 1, 2, 3};
   int WH[9]  = '{3, 4, 5, 131, 132, 133, 3, 4, 5};

   sobel_pixel_fetcher dut (
      .clk               (clk),
      .rst               (rst),
      .loadStart         (loadStart),
      .readAddress       (readAddress),
      .numPixToLoad      (numPixToLoad),
      .busy              (busy),
      .loadDone          (loadDone),
      .window            (window),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: decides acceptance at the negedge before the accepting edge, data = address>>2.
   initial begin
      forever begin
         @(negedge clk);
         if (loadDone === 1'b1) done_cnt++;
         if (q_due.size() > 0 && q_due[0] <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = q_addr[0] >> 2;
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'hdead_beef;
         end
         if (avm_read === 1'b1) begin
            if (stall_left > 0 && acc_log.size() == stall_idx) begin
               avm_waitrequest = 1'b1;
               if (stall_seen > 0 && avm_address !== stall_addr) hold_bad++;
               stall_addr = avm_address;
               stall_seen++;
               stall_left--;
            end else begin
               avm_waitrequest = 1'b0;
               acc_log.push_back(avm_address);
               q_addr.push_back(avm_address);
               q_due.push_back(cyc + lat_cfg);
            end
         end else begin
            avm_waitrequest = 1'b0;
         end
         if (q_addr.size() > max_q) max_q = q_addr.size();
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic start_load(input logic [31:0] base, input logic [3:0] npix, output int t0);
      @(negedge clk);
      loadStart    = 1'b1;
      readAddress  = base;
      numPixToLoad = npix;
      t0           = cyc + 1;
      @(negedge clk);
      loadStart = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int t0, output int lat);
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         if (loadDone === 1'b1) begin
            lat = cyc - t0;
            break;
         end
         @(negedge clk);
      end
      if (lat < 0) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic check_win(input string tag, input int exp[9]);
      for (int i = 0; i < 9; i++)
         check($sformatf("%s_pix%0d", tag, i), {24'd0, window[i*8 +: 8]}, exp[i]);
   endtask

   task automatic check_addrs(input string tag, input logic [31:0] base, input int n);
      check({tag, "_nreads"}, acc_log.size(), n);
      for (int k = 0; k < n && k < acc_log.size(); k++)
         check($sformatf("%s_addr%0d", tag, k), acc_log[k], base + OFF[k]);
   endtask

   initial begin
      int t0;
      int lat;
      int d0;
      #100000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1);
   end

   initial begin
      int t0;
      int lat;
      int d0;
      rst          = 1'b1;
      loadStart    = 1'b0;
      readAddress  = '0;
      numPixToLoad = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_loaddone", loadDone, 0);
      check("rst_avm_read", avm_read, 0);
      check("rst_avm_address", avm_address, 0);
      check("rst_window_zero", 32'(window == '0), 1);
      rst = 1'b0;

      // 9-load at 0, zero-wait slave
      acc_log.delete(); d0 = done_cnt;
      start_load(32'h0, 4'd9, t0);
      wait_done("b", t0, lat);
      check("b_latency", lat, 11);
      check_win("b", W9);
      repeat (3) @(negedge clk);
      check_addrs("b", 32'h0, 9);
      check("b_done_pulses", done_cnt - d0, 1);

      // 3-load at 0xC slides one column; window stable mid-load
      acc_log.delete(); d0 = done_cnt;
      start_load(32'hC, 4'd3, t0);
      repeat (2) @(negedge clk);
      check("c_busy_mid", busy, 1);
      check("c_window_stable", {24'd0, window[2*8 +: 8]}, 2);
      wait_done("c", t0, lat);
      check_win("c", W3);
      repeat (3) @(negedge clk);
      check_addrs("c", 32'hC, 3);
      check("c_done_pulses", done_cnt - d0, 1);

      // waitrequest held 5 cycles on request 2
      acc_log.delete(); stall_idx = 2; stall_left = 5; stall_seen = 0; hold_bad = 0;
      start_load(32'h0, 4'd9, t0);
      wait_done("d", t0, lat);
      check_win("d", W9);
      repeat (3) @(negedge clk);
      check_addrs("d", 32'h0, 9);
      check("d_stall_cycles", stall_seen, 5);
      check("d_addr_held", hold_bad, 0);
      check("d_stall_addr", stall_addr, 5120);
      stall_idx = -1;

      // 8-cycle slave latency, pending capped at 4
      lat_cfg = 8; max_q = 0; acc_log.delete();
      start_load(32'hC, 4'd9, t0);
      wait_done("e", t0, lat);
      check_win("e", WH);
      repeat (3) @(negedge clk);
      check_addrs("e", 32'hC, 9);
      check("e_max_pending", max_q, 4);
      lat_cfg = 1;

      // loadStart while busy and in the DONE cycle is ignored
      acc_log.delete(); d0 = done_cnt;
      start_load(32'h0, 4'd9, t0);
      repeat (3) @(negedge clk);
      loadStart = 1'b1; readAddress = 32'h100; numPixToLoad = 4'd3;
      @(negedge clk);
      loadStart = 1'b0;
      wait_done("f", t0, lat);
      loadStart = 1'b1; readAddress = 32'h200; numPixToLoad = 4'd3;
      @(negedge clk);
      loadStart = 1'b0;
      repeat (15) @(negedge clk);
      check_addrs("f", 32'h0, 9);
      check("f_done_pulses", done_cnt - d0, 1);
      check("f_busy_after", busy, 0);
      check("f_read_after", avm_read, 0);
      check_win("f", W9);

      // reset mid-load with responses outstanding
      lat_cfg = 8; acc_log.delete(); d0 = done_cnt;
      start_load(32'hC, 4'd9, t0);
      for (int i = 0; i < 50; i++) begin
         if (acc_log.size() >= 4) break;
         @(negedge clk);
      end
      check("g_reached_4_reads", 32'(acc_log.size() >= 4), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("g_read_dropped", avm_read, 0);
      check("g_busy_cleared", busy, 0);
      check("g_window_cleared", 32'(window == '0), 1);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (q_addr.size() == 0) break;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("g_stale_window", 32'(window == '0), 1);
      check("g_stale_no_done", done_cnt - d0, 0);
      check("g_stale_busy", busy, 0);
      lat_cfg = 1; acc_log.delete();
      start_load(32'h0, 4'd9, t0);
      wait_done("g2", t0, lat);
      check("g2_latency", lat, 11);
      check_win("g2", W9);
      repeat (3) @(negedge clk);
      check_addrs("g2", 32'h0, 9);

      // numPixToLoad = 0 behaves as a 9-load
      acc_log.delete();
      start_load(32'hC, 4'd0, t0);
      wait_done("h", t0, lat);
      check_win("h", WH);
      repeat (3) @(negedge clk);
      check_addrs("h", 32'hC, 9);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
